// File: rtl/pic_host_sequencer.sv
// rtl/pic_host_sequencer.sv - CPU-side bus master for an 8259-compatible PIC
//
// Programs the PIC with an ICW1..ICW4 burst, answers INT with the two-pulse
// INTA acknowledge (capturing the vector), and runs single read/write bus
// cycles for the system side.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   init_start            - start ICW burst (IDLE only)
//   cfg_icw1..cfg_icw4    - ICW values, latched when init_start is taken
//   init_done             - PIC has been programmed
//   cmd_valid/cmd_ready   - command handshake; cmd_rd, cmd_a0, cmd_wdata
//   rsp_valid/rsp_data    - one-cycle read data pulse (HOLD cycle)
//   int_en                - allow acknowledge of INT
//   vec_valid/vec_data    - one-cycle vector pulse
//   busy                  - sequencer not idle
//   INT                   - asynchronous interrupt request from the PIC
//   INTA_n, CS_n, RD_n, WR_n, A0, D_out, D_oe, D_in - PIC host pins
module pic_host_sequencer #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init_start,
    input  logic [7:0] cfg_icw1,
    input  logic [7:0] cfg_icw2,
    input  logic [7:0] cfg_icw3,
    input  logic [7:0] cfg_icw4,
    output logic       init_done,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    input  logic       int_en,
    output logic       vec_valid,
    output logic [7:0] vec_data,
    output logic       busy,
    input  logic       INT,
    output logic       INTA_n,
    output logic       CS_n,
    output logic       RD_n,
    output logic       WR_n,
    output logic       A0,
    output logic [7:0] D_out,
    output logic       D_oe,
    input  logic [7:0] D_in
);

    typedef enum logic [3:0] {
        IDLE, SETUP, STROBE, HOLD, GAP, ACK1, ACK_GAP, ACK2, ACK_END
    } state_t;

    localparam int MAX_W   = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CNT_MAX = (MAX_W > 3) ? MAX_W : 3;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);
    localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(2);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;

    logic       r_int_s1;
    logic       r_int_sync;

    // Latched init configuration; only the SNGL/IC4 bits of ICW1 steer the
    // burst, the ICW1 byte itself goes straight into r_wdata at accept.
    logic       r_sngl;
    logic       r_ic4;
    logic [7:0] r_icw2;
    logic [7:0] r_icw3;
    logic [7:0] r_icw4;
    logic [1:0] r_idx;
    logic       r_in_init;

    logic       r_rd;
    logic       r_a0;
    logic [7:0] r_wdata;
    logic       r_init_done;
    logic [7:0] r_rsp_data;
    logic [7:0] r_vec_data;

    logic       w_ack_req;
    logic       w_cmd_ready;
    logic       w_accept_init;
    logic       w_accept_cmd;
    logic       w_pulse_last;
    logic [1:0] w_next_idx;
    logic       w_last_icw;
    logic [7:0] w_next_data;
    logic       w_bus;

    assign w_ack_req    = r_init_done & int_en & r_int_sync;
    assign w_cmd_ready  = (r_state == IDLE) & r_init_done & ~init_start & ~(int_en & r_int_sync);
    assign w_pulse_last = (r_cnt == PULSE_LAST);

    // Which ICW follows the one just sent (ICW3 only in cascade mode,
    // ICW4 only when IC4 is set).
    always_comb begin
        w_next_idx = 2'd3;
        w_last_icw = 1'b0;
        case (r_idx)
            2'd0: w_next_idx = 2'd1;
            2'd1: begin
                if (!r_sngl)    w_next_idx = 2'd2;
                else if (r_ic4) w_next_idx = 2'd3;
                else            w_last_icw = 1'b1;
            end
            2'd2: begin
                if (r_ic4) w_next_idx = 2'd3;
                else       w_last_icw = 1'b1;
            end
            default: w_last_icw = 1'b1;
        endcase
    end

    always_comb begin
        case (w_next_idx)
            2'd1:    w_next_data = r_icw2;
            2'd2:    w_next_data = r_icw3;
            default: w_next_data = r_icw4;
        endcase
    end

    always_comb begin
        w_next_state  = r_state;
        w_accept_init = 1'b0;
        w_accept_cmd  = 1'b0;
        case (r_state)
            IDLE: begin
                if (init_start) begin
                    w_next_state  = SETUP;
                    w_accept_init = 1'b1;
                end else if (w_ack_req) begin
                    w_next_state = ACK1;
                end else if (cmd_valid && w_cmd_ready) begin
                    w_next_state = SETUP;
                    w_accept_cmd = 1'b1;
                end
            end
            SETUP:   w_next_state = STROBE;
            STROBE:  if (w_pulse_last) w_next_state = HOLD;
            HOLD:    w_next_state = (r_in_init && !w_last_icw) ? GAP : IDLE;
            GAP:     w_next_state = SETUP;
            ACK1:    if (w_pulse_last) w_next_state = ACK_GAP;
            ACK_GAP: if (r_cnt == GAP_LAST) w_next_state = ACK2;
            ACK2:    if (w_pulse_last) w_next_state = ACK_END;
            ACK_END: if (r_cnt == END_LAST) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_int_s1    <= 1'b0;
            r_int_sync  <= 1'b0;
            r_sngl      <= 1'b0;
            r_ic4       <= 1'b0;
            r_icw2      <= 8'h00;
            r_icw3      <= 8'h00;
            r_icw4      <= 8'h00;
            r_idx       <= 2'd0;
            r_in_init   <= 1'b0;
            r_rd        <= 1'b0;
            r_a0        <= 1'b0;
            r_wdata     <= 8'h00;
            r_init_done <= 1'b0;
            r_rsp_data  <= 8'h00;
            r_vec_data  <= 8'h00;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= (w_next_state != r_state || r_state == IDLE) ? '0 : r_cnt + 1'b1;
            r_int_s1   <= INT;
            r_int_sync <= r_int_s1;

            if (w_accept_init) begin
                r_sngl      <= cfg_icw1[1];
                r_ic4       <= cfg_icw1[0];
                r_icw2      <= cfg_icw2;
                r_icw3      <= cfg_icw3;
                r_icw4      <= cfg_icw4;
                r_idx       <= 2'd0;
                r_in_init   <= 1'b1;
                r_init_done <= 1'b0;
                r_rd        <= 1'b0;
                r_a0        <= 1'b0;
                r_wdata     <= cfg_icw1 | 8'h10;
            end else if (w_accept_cmd) begin
                r_in_init <= 1'b0;
                r_rd      <= cmd_rd;
                r_a0      <= cmd_a0;
                r_wdata   <= cmd_wdata;
            end

            // Load the next ICW at the end of HOLD so it is ready by SETUP.
            if (r_state == HOLD && r_in_init) begin
                if (w_last_icw) begin
                    r_init_done <= 1'b1;
                    r_in_init   <= 1'b0;
                end else begin
                    r_idx   <= w_next_idx;
                    r_a0    <= 1'b1;
                    r_wdata <= w_next_data;
                end
            end

            if (r_state == STROBE && w_pulse_last && r_rd)
                r_rsp_data <= D_in;
            if (r_state == ACK2 && w_pulse_last)
                r_vec_data <= D_in;
        end
    end

    assign w_bus     = (r_state == SETUP) || (r_state == STROBE) || (r_state == HOLD);
    assign CS_n      = ~w_bus;
    assign A0        = w_bus & r_a0;
    assign D_oe      = w_bus & ~r_rd;
    assign D_out     = D_oe ? r_wdata : 8'h00;
    assign WR_n      = ~((r_state == STROBE) & ~r_rd);
    assign RD_n      = ~((r_state == STROBE) & r_rd);
    assign INTA_n    = ~((r_state == ACK1) || (r_state == ACK2));
    assign rsp_valid = (r_state == HOLD) & r_rd;
    assign rsp_data  = r_rsp_data;
    assign vec_valid = (r_state == ACK_END) && (r_cnt == '0);
    assign vec_data  = r_vec_data;
    assign init_done = r_init_done;
    assign cmd_ready = w_cmd_ready;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pic_host_sequencer.sv
// tb/tb_pic_host_sequencer.sv - self-checking bench for pic_host_sequencer
module tb_pic_host_sequencer;

    localparam int PULSE_W = 2;
    localparam int GAP_W   = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       init_start;
    logic [7:0] cfg_icw1, cfg_icw2, cfg_icw3, cfg_icw4;
    logic       init_done;
    logic       cmd_valid, cmd_ready, cmd_rd, cmd_a0;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       int_en;
    logic       vec_valid;
    logic [7:0] vec_data;
    logic       busy;
    logic       INT;
    logic       INTA_n, CS_n, RD_n, WR_n, A0;
    logic [7:0] D_out;
    logic       D_oe;
    logic [7:0] D_in;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    pic_host_sequencer #(.PULSE_W(PULSE_W), .GAP_W(GAP_W)) dut (
        .clk(clk), .reset(reset), .init_start(init_start),
        .cfg_icw1(cfg_icw1), .cfg_icw2(cfg_icw2), .cfg_icw3(cfg_icw3), .cfg_icw4(cfg_icw4),
        .init_done(init_done), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rd(cmd_rd), .cmd_a0(cmd_a0), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .int_en(int_en),
        .vec_valid(vec_valid), .vec_data(vec_data), .busy(busy), .INT(INT),
        .INTA_n(INTA_n), .CS_n(CS_n), .RD_n(RD_n), .WR_n(WR_n), .A0(A0),
        .D_out(D_out), .D_oe(D_oe), .D_in(D_in)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Bus monitor: each completed low pulse on WR_n/RD_n/INTA_n/CS_n is
    // logged with its start cycle, width and the A0/D_out/D_oe seen at start.
    typedef struct {
        int         t;
        int         w;
        logic       a0;
        logic [7:0] d;
        logic       oe;
    } pulse_t;

    pulse_t pend [4];
    int     plen [4];
    bit     pprev [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
    pulse_t wr_q[$], rd_q[$], ia_q[$], cs_q[$];
    int         vec_t[$], rsp_t[$];
    logic [7:0] vec_d[$], rsp_d[$];

    task automatic track(input int i, input logic lvl);
        if (lvl === 1'b0) begin
            if (pprev[i]) begin
                pend[i].t  = cyc;
                pend[i].a0 = A0;
                pend[i].d  = D_out;
                pend[i].oe = D_oe;
                plen[i]    = 0;
            end
            plen[i]++;
            pprev[i] = 1'b0;
        end else begin
            if (!pprev[i]) begin
                pend[i].w = plen[i];
                case (i)
                    0:       wr_q.push_back(pend[i]);
                    1:       rd_q.push_back(pend[i]);
                    2:       ia_q.push_back(pend[i]);
                    default: cs_q.push_back(pend[i]);
                endcase
            end
            pprev[i] = 1'b1;
        end
    endtask

    always @(negedge clk) begin
        track(0, WR_n);
        track(1, RD_n);
        track(2, INTA_n);
        track(3, CS_n);
        if (vec_valid === 1'b1) begin vec_t.push_back(cyc); vec_d.push_back(vec_data); end
        if (rsp_valid === 1'b1) begin rsp_t.push_back(cyc); rsp_d.push_back(rsp_data); end
    end

    task automatic clear_mon();
        wr_q = {}; rd_q = {}; ia_q = {}; cs_q = {};
        vec_t = {}; vec_d = {}; rsp_t = {}; rsp_d = {};
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: list of {A0,data} writes an init burst must produce.
    task automatic do_init(input logic [7:0] i1, input logic [7:0] i2,
                           input logic [7:0] i3, input logic [7:0] i4);
        logic [8:0] exp_q[$];
        int m, n, td;
        exp_q = {};
        exp_q.push_back({1'b0, i1 | 8'h10});
        exp_q.push_back({1'b1, i2});
        if (!i1[1]) exp_q.push_back({1'b1, i3});
        if (i1[0])  exp_q.push_back({1'b1, i4});
        n = exp_q.size();
        clear_mon();
        cfg_icw1 = i1; cfg_icw2 = i2; cfg_icw3 = i3; cfg_icw4 = i4;
        init_start = 1'b1;
        m = cyc;
        tick();
        init_start = 1'b0;
        cfg_icw1 = 8'($urandom); cfg_icw2 = 8'($urandom);
        cfg_icw3 = 8'($urandom); cfg_icw4 = 8'($urandom);
        chk("init_done_cleared", init_done, 0);
        chk("init_busy", busy, 1);
        chk("init_cmd_ready", cmd_ready, 0);
        td = -1;
        for (int i = 0; i < 200 && td < 0; i++) begin
            if (init_done === 1'b1) td = cyc;
            else tick();
        end
        chk("init_done_cycle", td - m, 5 * n);
        chk("init_idle_at_done", busy, 0);
        tick(); tick();
        chk("init_write_count", wr_q.size(), n);
        for (int i = 0; i < n && i < wr_q.size(); i++) begin
            chk("icw_a0", wr_q[i].a0, exp_q[i][8]);
            chk("icw_data", wr_q[i].d, exp_q[i][7:0]);
            chk("icw_oe", wr_q[i].oe, 1);
            chk("icw_wr_width", wr_q[i].w, PULSE_W);
            chk("icw_wr_start", wr_q[i].t - m, 2 + 5 * i);
        end
        if (cs_q.size() > 0) chk("icw_cs_width", cs_q[0].w, PULSE_W + 2);
        chk("init_cs_count", cs_q.size(), n);
    endtask

    // INT raised at cycle m: sync high in IDLE cycle k=m+2.
    task automatic do_ack(input logic [7:0] v, input bit drop_en);
        int m;
        clear_mon();
        int_en = 1'b1;
        D_in = ~v;
        m = cyc;
        INT = 1'b1;
        while (cyc < m + 12) begin
            tick();
            if (cyc == m + 7) D_in = v;
            if (cyc == m + 7 && drop_en) int_en = 1'b0;
            if (cyc == m + 9) begin INT = 1'b0; D_in = 8'($urandom); end
            if (cyc < m + 12 && cyc > m + 2) chk("ack_cs_high", CS_n, 1);
        end
        chk("ack_idle_k10", busy, 0);
        repeat (6) tick();
        chk("ack_inta_count", ia_q.size(), 2);
        if (ia_q.size() == 2) begin
            chk("inta1_start", ia_q[0].t - m, 3);
            chk("inta1_width", ia_q[0].w, PULSE_W);
            chk("inta_gap", ia_q[1].t - (ia_q[0].t + ia_q[0].w), GAP_W);
            chk("inta2_width", ia_q[1].w, PULSE_W);
            chk("inta_oe", ia_q[1].oe, 0);
        end
        chk("vec_count", vec_t.size(), 1);
        if (vec_t.size() == 1) begin
            chk("vec_cycle", vec_t[0] - m, 9);
            chk("vec_data", vec_d[0], v);
        end
        chk("ack_no_cs", cs_q.size(), 0);
        int_en = 1'b1;
    endtask

    task automatic do_cmd(input logic rd, input logic a0, input logic [7:0] wd, input logic [7:0] din);
        int m, w;
        clear_mon();
        w = 0;
        while (cmd_ready !== 1'b1 && w < 50) begin tick(); w++; end
        chk("cmd_ready_wait", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_rd = rd; cmd_a0 = a0; cmd_wdata = wd; D_in = din;
        m = cyc;
        tick();
        cmd_valid = 1'b0;
        cmd_wdata = 8'($urandom);
        cmd_a0 = ~a0;
        chk("cmd_busy", busy, 1);
        while (cyc < m + 7) tick();
        D_in = 8'($urandom);
        chk("cmd_cs_count", cs_q.size(), 1);
        if (cs_q.size() == 1) begin
            chk("cmd_cs_start", cs_q[0].t - m, 1);
            chk("cmd_cs_width", cs_q[0].w, PULSE_W + 2);
            chk("cmd_cs_a0", cs_q[0].a0, a0);
        end
        if (rd) begin
            chk("rd_count", rd_q.size(), 1);
            chk("rd_no_wr", wr_q.size(), 0);
            if (rd_q.size() == 1) begin
                chk("rd_start", rd_q[0].t - m, 2);
                chk("rd_width", rd_q[0].w, PULSE_W);
                chk("rd_oe", rd_q[0].oe, 0);
            end
            chk("rsp_count", rsp_t.size(), 1);
            if (rsp_t.size() == 1) begin
                chk("rsp_cycle", rsp_t[0] - m, 2 + PULSE_W);
                chk("rsp_data", rsp_d[0], din);
            end
        end else begin
            chk("wr_count", wr_q.size(), 1);
            chk("wr_no_rd", rd_q.size(), 0);
            chk("wr_no_rsp", rsp_t.size(), 0);
            if (wr_q.size() == 1) begin
                chk("wr_start", wr_q[0].t - m, 2);
                chk("wr_width", wr_q[0].w, PULSE_W);
                chk("wr_a0", wr_q[0].a0, a0);
                chk("wr_data", wr_q[0].d, wd);
                chk("wr_oe", wr_q[0].oe, 1);
            end
        end
    endtask

    initial begin
        int m, hi;
        logic [7:0] v;
        reset = 1'b1; init_start = 1'b0; cmd_valid = 1'b0; cmd_rd = 1'b0; cmd_a0 = 1'b0;
        cmd_wdata = 8'h00; int_en = 1'b0; INT = 1'b0; D_in = 8'h00;
        cfg_icw1 = 8'h00; cfg_icw2 = 8'h00; cfg_icw3 = 8'h00; cfg_icw4 = 8'h00;
        repeat (3) tick();
        chk("rst_cs_n", CS_n, 1);   chk("rst_rd_n", RD_n, 1);
        chk("rst_wr_n", WR_n, 1);   chk("rst_inta_n", INTA_n, 1);
        chk("rst_a0", A0, 0);       chk("rst_d_out", D_out, 0);
        chk("rst_d_oe", D_oe, 0);   chk("rst_init_done", init_done, 0);
        chk("rst_rsp_valid", rsp_valid, 0); chk("rst_vec_valid", vec_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);   chk("rst_vec_data", vec_data, 0);
        chk("rst_busy", busy, 0);   chk("rst_cmd_ready", cmd_ready, 0);
        reset = 1'b0;
        tick();

        // INT before init_done is ignored.
        clear_mon();
        int_en = 1'b1; INT = 1'b1;
        repeat (8) tick();
        chk("preinit_no_ack", busy, 0);
        chk("preinit_inta_high", INTA_n, 1);
        INT = 1'b0;
        repeat (4) tick();

        do_init(8'h13, 8'h20, 8'h00, 8'h01);
        do_init(8'h11, 8'($urandom), 8'($urandom), 8'($urandom));
        for (int i = 0; i < 3; i++)
            do_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));

        // int_en=0 blocks the acknowledge and keeps cmd_ready up.
        clear_mon();
        int_en = 1'b0; INT = 1'b1;
        repeat (6) tick();
        chk("int_dis_no_ack", busy, 0);
        chk("int_dis_cmd_ready", cmd_ready, 1);
        INT = 1'b0;
        repeat (4) tick();

        do_ack(8'h24, 1'b0);
        for (int i = 0; i < 2; i++) do_ack(8'($urandom), 1'b1);

        do_cmd(1'b0, 1'b0, 8'h20, 8'h00);
        do_cmd(1'b1, 1'b0, 8'h00, 8'h81);
        for (int i = 0; i < 6; i++)
            do_cmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom));

        // INT and cmd_valid in the same IDLE cycle: acknowledge first.
        clear_mon();
        int_en = 1'b1;
        v = 8'($urandom);
        m = cyc;
        INT = 1'b1;
        tick(); tick();
        cmd_valid = 1'b1; cmd_rd = 1'b0; cmd_a0 = 1'b1; cmd_wdata = v;
        hi = 0;
        while (cyc < m + 12) begin
            if (cmd_ready === 1'b1) hi++;
            tick();
            if (cyc == m + 9) INT = 1'b0;
        end
        chk("coll_ready_low_during_ack", hi, 0);
        chk("coll_ready_after", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        while (cyc < m + 20) tick();
        chk("coll_inta_count", ia_q.size(), 2);
        if (ia_q.size() == 2) chk("coll_inta_start", ia_q[0].t - m, 3);
        chk("coll_wr_count", wr_q.size(), 1);
        if (wr_q.size() == 1) begin
            chk("coll_wr_start", wr_q[0].t - m, 14);
            chk("coll_wr_data", wr_q[0].d, v);
        end

        // Reset during STROBE of an init write.
        clear_mon();
        cfg_icw1 = 8'h13; cfg_icw2 = 8'($urandom);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        chk("abort_wr_low", WR_n, 0);
        reset = 1'b1;
        tick();
        chk("abort_wr_n", WR_n, 1);
        chk("abort_cs_n", CS_n, 1);
        chk("abort_init_done", init_done, 0);
        chk("abort_busy", busy, 0);
        chk("abort_d_oe", D_oe, 0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("abort_no_vec", vec_t.size(), 0);
        chk("abort_no_rsp", rsp_t.size(), 0);
        chk("abort_one_wr", wr_q.size(), 1);
        chk("abort_stays_undone", init_done, 0);
        chk("abort_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
